// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared load/store encodings, access-size decode and request fault check.
package lsu_mem_ctrl_pkg;

    // Load ops: LB LH LW LBU LHU; store ops reuse the first three codes (SB SH SW).
    localparam logic [2:0] OpB  = 3'b000;
    localparam logic [2:0] OpH  = 3'b001;
    localparam logic [2:0] OpW  = 3'b010;
    localparam logic [2:0] OpBu = 3'b100;
    localparam logic [2:0] OpHu = 3'b101;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

    // Access size in bytes; illegal codes decode to 4 but are faulted separately.
    function automatic logic [2:0] op_size(input logic [2:0] op);
        case (op)
            OpB, OpBu: op_size = 3'd1;
            OpH, OpHu: op_size = 3'd2;
            default:   op_size = 3'd4;
        endcase
    endfunction

    function automatic logic op_illegal(input logic is_store, input logic [2:0] op);
        if (is_store) begin
            op_illegal = !(op inside {OpB, OpH, OpW});
        end else begin
            op_illegal = op inside {3'b011, 3'b110, 3'b111};
        end
    endfunction

    // Illegal op, misaligned half/word, or access running past the end of memory.
    function automatic logic lsu_fault(input logic        is_store,
                                       input logic [2:0]  op,
                                       input logic [31:0] addr,
                                       input int unsigned mem_bytes);
        logic [2:0]  size;
        logic [32:0] end_addr;
        logic        misalign;
        size     = op_size(op);
        end_addr = {1'b0, addr} + 33'(size);
        misalign = ((size == 3'd2) && addr[0]) || ((size == 3'd4) && (addr[1:0] != 2'b00));
        lsu_fault = op_illegal(is_store, op) || misalign || (end_addr > 33'(mem_bytes));
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_store_buffer.sv
// Store buffer FIFO with a parallel word-address compare across valid entries.
module lsu_store_buffer
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  sb_entry_t   push_entry_i,
    input  logic        pop_i,
    input  logic [29:0] match_waddr_i,
    output sb_entry_t   head_o,
    output logic        hit_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    sb_entry_t         entries_q [Depth];
    logic [Depth-1:0]  valid_q, valid_d;
    logic [PtrW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]   count_q, count_d;

    // Entry payload needs no reset; validity is tracked separately.
    always_ff @(posedge clk) begin
        if (push_i) entries_q[tail_q] <= push_entry_i;
    end

    // Pointer, count and valid-bit bookkeeping for push/pop.
    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PtrW'(1);
        end
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PtrW'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Any valid entry in the same word blocks a load (no forwarding).
    always_comb begin
        hit_o = 1'b0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (valid_q[i] && (entries_q[i].addr[31:2] == match_waddr_i)) hit_o = 1'b1;
        end
    end

    assign head_o  = entries_q[head_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: buffered stores on the write port, 1-cycle loads on the read port.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned SB_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_is_store_i,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        rsp_valid_o,
    output logic        rsp_is_store_o,
    output logic        rsp_fault_o,
    output logic [4:0]  rsp_rd_o,
    output logic [31:0] rsp_rdata_o,
    output logic        mem_write_en_o,
    output logic [2:0]  mem_write_op_o,
    output logic [31:0] mem_write_addr_o,
    output logic [31:0] mem_write_data_o,
    output logic        mem_read_en_o,
    output logic [2:0]  mem_read_op_o,
    output logic [31:0] mem_read_addr_o,
    input  logic [31:0] mem_read_data_i
);

    logic      req_fault, sb_hit, sb_full, sb_empty;
    logic      accept, push, load_acc;
    sb_entry_t sb_head, push_entry;

    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_is_store_q, rsp_is_store_d;
    logic        rsp_fault_q, rsp_fault_d;
    logic [4:0]  rsp_rd_q, rsp_rd_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    assign req_fault  = lsu_fault(req_is_store_i, req_op_i, req_addr_i, MEM_BYTES);
    assign push_entry = '{op: req_op_i, addr: req_addr_i, data: req_wdata_i};

    // Handshake: faults always accepted, stores need space, loads wait out word hazards.
    always_comb begin
        req_ready_o = 1'b1;
        if (!req_fault) req_ready_o = req_is_store_i ? !sb_full : !sb_hit;
        accept   = req_valid_i && req_ready_o;
        push     = accept && req_is_store_i && !req_fault;
        load_acc = accept && !req_is_store_i && !req_fault;
    end

    lsu_store_buffer #(
        .Depth (SB_DEPTH)
    ) u_store_buffer (
        .clk           (clk),
        .rst_n         (rst_n),
        .push_i        (push),
        .push_entry_i  (push_entry),
        .pop_i         (!sb_empty),
        .match_waddr_i (req_addr_i[31:2]),
        .head_o        (sb_head),
        .hit_o         (sb_hit),
        .full_o        (sb_full),
        .empty_o       (sb_empty)
    );

    // Memory ports: head entry drains every cycle; reads only while a load is accepted.
    always_comb begin
        mem_write_en_o   = !sb_empty;
        mem_write_op_o   = sb_empty ? 3'b000 : sb_head.op;
        mem_write_addr_o = sb_empty ? 32'h0 : sb_head.addr;
        mem_write_data_o = sb_empty ? 32'h0 : sb_head.data;
        mem_read_en_o    = load_acc;
        mem_read_op_o    = load_acc ? req_op_i : 3'b000;
        mem_read_addr_o  = load_acc ? req_addr_i : 32'h0;
    end

    // One response per accepted request, next cycle.
    always_comb begin
        rsp_valid_d    = accept;
        rsp_is_store_d = accept && req_is_store_i;
        rsp_fault_d    = accept && req_fault;
        rsp_rd_d       = accept ? req_rd_i : 5'd0;
        rsp_rdata_d    = load_acc ? mem_read_data_i : 32'h0;
    end

    // Response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q    <= 1'b0;
            rsp_is_store_q <= 1'b0;
            rsp_fault_q    <= 1'b0;
            rsp_rd_q       <= 5'd0;
            rsp_rdata_q    <= 32'h0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_store_q <= rsp_is_store_d;
            rsp_fault_q    <= rsp_fault_d;
            rsp_rd_q       <= rsp_rd_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_is_store_o = rsp_is_store_q;
    assign rsp_fault_o    = rsp_fault_q;
    assign rsp_rd_o       = rsp_rd_q;
    assign rsp_rdata_o    = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a byte-array data memory model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_is_store, rsp_fault;
    logic [4:0]  rsp_rd;
    logic [31:0] rsp_rdata;
    logic        mem_write_en, mem_read_en;
    logic [2:0]  mem_write_op, mem_read_op;
    logic [31:0] mem_write_addr, mem_write_data, mem_read_addr, mem_read_data;

    typedef struct {
        logic        is_store;
        logic        fault;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    rsp_t exp_rsp [$];
    wr_t  exp_wr  [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [7:0] mem     [4096] = '{default: 8'h00};
    logic [7:0] ref_mem [4096] = '{default: 8'h00};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_mem_ctrl #(
        .MEM_BYTES (4096),
        .SB_DEPTH  (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_is_store_i   (req_is_store),
        .req_op_i         (req_op),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_rd_i         (req_rd),
        .rsp_valid_o      (rsp_valid),
        .rsp_is_store_o   (rsp_is_store),
        .rsp_fault_o      (rsp_fault),
        .rsp_rd_o         (rsp_rd),
        .rsp_rdata_o      (rsp_rdata),
        .mem_write_en_o   (mem_write_en),
        .mem_write_op_o   (mem_write_op),
        .mem_write_addr_o (mem_write_addr),
        .mem_write_data_o (mem_write_data),
        .mem_read_en_o    (mem_read_en),
        .mem_read_op_o    (mem_read_op),
        .mem_read_addr_o  (mem_read_addr),
        .mem_read_data_i  (mem_read_data)
    );

    // Data memory: asynchronous, sign/zero-extending read port.
    logic [11:0] ra;
    logic [7:0]  r0, r1, r2, r3;
    always_comb begin
        ra = mem_read_addr[11:0];
        r0 = mem[ra];
        r1 = mem[ra + 12'd1];
        r2 = mem[ra + 12'd2];
        r3 = mem[ra + 12'd3];
        case (mem_read_op)
            3'b000:  mem_read_data = {{24{r0[7]}}, r0};
            3'b100:  mem_read_data = {24'h0, r0};
            3'b001:  mem_read_data = {{16{r1[7]}}, r1, r0};
            3'b101:  mem_read_data = {16'h0, r1, r0};
            default: mem_read_data = {r3, r2, r1, r0};
        endcase
    end

    // Data memory: synchronous write port.
    logic [11:0] wa;
    always @(posedge clk) begin
        if (mem_write_en) begin
            wa = mem_write_addr[11:0];
            mem[wa] <= mem_write_data[7:0];
            if (mem_write_op != 3'b000) mem[wa + 12'd1] <= mem_write_data[15:8];
            if (mem_write_op == 3'b010) begin
                mem[wa + 12'd2] <= mem_write_data[23:16];
                mem[wa + 12'd3] <= mem_write_data[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic exp_fault(input logic st, input logic [2:0] op, input logic [31:0] a);
        int   sz;
        logic bad;
        bad = 1'b0;
        sz  = 0;
        if (st) begin
            case (op)
                3'd0: sz = 1;
                3'd1: sz = 2;
                3'd2: sz = 4;
                default: bad = 1'b1;
            endcase
        end else begin
            case (op)
                3'd0, 3'd4: sz = 1;
                3'd1, 3'd5: sz = 2;
                3'd2:       sz = 4;
                default:    bad = 1'b1;
            endcase
        end
        if (!bad) begin
            if (sz == 2 && a[0]) bad = 1'b1;
            if (sz == 4 && a[1:0] != 2'b00) bad = 1'b1;
            if (64'(a) + 64'(sz) > 64'd4096) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = ref_mem[a[11:0]];
        b1 = ref_mem[a[11:0] + 12'd1];
        b2 = ref_mem[a[11:0] + 12'd2];
        b3 = ref_mem[a[11:0] + 12'd3];
        case (op)
            3'd0:    return {{24{b0[7]}}, b0};
            3'd4:    return {24'h0, b0};
            3'd1:    return {{16{b1[7]}}, b1, b0};
            3'd5:    return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    // Present one request, wait for acceptance (bounded), record expectations.
    task automatic issue(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input int exp_stall);
        int   stalls = 0;
        bit   done   = 0;
        logic f;
        rsp_t e;
        wr_t  w;
        req_valid    = 1'b1;
        req_is_store = st;
        req_op       = op;
        req_addr     = a;
        req_wdata    = wd;
        req_rd       = rd;
        while (!done) begin
            @(negedge clk);
            if (req_ready) begin
                done = 1;
                f = exp_fault(st, op, a);
                check("rd_en", 32'(mem_read_en), 32'(!st && !f));
                if (!st && !f) check("rd_addr", mem_read_addr, a);
                e.is_store = st;
                e.fault    = f;
                e.rd       = rd;
                e.rdata    = (!st && !f) ? ref_load(op, a) : 32'h0;
                e.cyc      = cyc;
                exp_rsp.push_back(e);
                if (st && !f) begin
                    ref_mem[a[11:0]] = wd[7:0];
                    if (op != 3'd0) ref_mem[a[11:0] + 12'd1] = wd[15:8];
                    if (op == 3'd2) begin
                        ref_mem[a[11:0] + 12'd2] = wd[23:16];
                        ref_mem[a[11:0] + 12'd3] = wd[31:24];
                    end
                    w.op   = op;
                    w.addr = a;
                    w.data = wd;
                    exp_wr.push_back(w);
                end
            end else begin
                stalls++;
                if (stalls > 20) begin
                    check("stall_timeout", 32'd1, 32'd0);
                    req_valid = 1'b0;
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        check("stall", 32'(stalls), 32'(exp_stall));
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Response and write-port scoreboards.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                automatic rsp_t e = exp_rsp.pop_front();
                check("rsp_is_store", 32'(rsp_is_store), 32'(e.is_store));
                check("rsp_fault", 32'(rsp_fault), 32'(e.fault));
                check("rsp_rd", 32'(rsp_rd), 32'(e.rd));
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end
        if (rst_n && mem_write_en) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'd1, 32'd0);
            end else begin
                automatic wr_t w = exp_wr.pop_front();
                check("wr_op", 32'(mem_write_op), 32'(w.op));
                check("wr_addr", mem_write_addr, w.addr);
                check("wr_data", mem_write_data, w.data);
            end
        end
    end

    initial begin
        int unsigned chk_addrs [13] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h400,
                                        32'h401, 32'h402, 32'h500, 32'hFFF, 32'h300, 32'h301,
                                        32'h303};
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_op       = 3'd0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_wr_en", 32'(mem_write_en), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        idle(1);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_is_store", 32'(rsp_is_store), 32'd0);
        check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rd_en", 32'(mem_read_en), 32'd0);

        // Store then load of a different word: no stall.
        issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd1, 0);
        issue(1'b0, 3'd2, 32'h104, 32'h0, 5'd3, 0);
        idle(2);
        // Store then load of the same word: one-cycle stall until the drain.
        issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd2, 0);
        issue(1'b0, 3'd2, 32'h100, 32'h0, 5'd7, 1);
        // Byte stores back to back.
        issue(1'b1, 3'd0, 32'h200, 32'h00000080, 5'd0, 0);
        issue(1'b1, 3'd0, 32'h400, 32'hAAAAAA11, 5'd0, 0);
        issue(1'b1, 3'd0, 32'h401, 32'h00000022, 5'd0, 0);
        issue(1'b1, 3'd0, 32'h402, 32'h00000033, 5'd0, 0);
        issue(1'b0, 3'd0, 32'h200, 32'h0, 5'd9, 0);
        issue(1'b0, 3'd4, 32'h200, 32'h0, 5'd10, 0);
        issue(1'b0, 3'd2, 32'h400, 32'h0, 5'd11, 0);
        issue(1'b0, 3'd5, 32'h402, 32'h0, 5'd12, 0);
        issue(1'b1, 3'd1, 32'h500, 32'h12348001, 5'd0, 0);
        issue(1'b0, 3'd1, 32'h500, 32'h0, 5'd13, 1);
        idle(3);
        // Faults: no memory access, rdata 0.
        issue(1'b0, 3'd1, 32'h103, 32'h0, 5'd14, 0);
        issue(1'b1, 3'd2, 32'h102, 32'h55555555, 5'd15, 0);
        issue(1'b0, 3'd2, 32'hFFE, 32'h0, 5'd16, 0);
        issue(1'b0, 3'd3, 32'h0, 32'h0, 5'd17, 0);
        issue(1'b1, 3'd3, 32'h10, 32'h66666666, 5'd18, 0);
        issue(1'b0, 3'd0, 32'h1000, 32'h0, 5'd19, 0);
        // Legal accesses right at the top of memory.
        issue(1'b0, 3'd2, 32'hFFC, 32'h0, 5'd20, 0);
        issue(1'b1, 3'd0, 32'hFFF, 32'h000000A5, 5'd21, 0);
        issue(1'b0, 3'd4, 32'hFFF, 32'h0, 5'd22, 1);
        idle(2);

        // Reset while a store is waiting to drain drops it and its response.
        issue(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 5'd23, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_en", 32'(mem_write_en), 32'd0);
        check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_rsp.delete();
        exp_wr.delete();
        for (int i = 0; i < 4; i++) ref_mem[12'h300 + 12'(i)] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        idle(2);
        issue(1'b0, 3'd2, 32'h300, 32'h0, 5'd24, 0);
        idle(3);

        check("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
        foreach (chk_addrs[i]) begin
            check("mem_byte", 32'(mem[chk_addrs[i][11:0]]), 32'(ref_mem[chk_addrs[i][11:0]]));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
